// File: rtl/alu_arbiter_pkg.sv
// Shared widths, ALU opcode encodings and request payload type for the ALU arbiter.
package alu_arbiter_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] ALU_OP_ADD = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SUB = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_OP_AND = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OP_OR  = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_OP_XOR = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_OP_LT  = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_OP_LTU = 4'd6;

    localparam logic ALU_ARB_SRC_EX = 1'b0;
    localparam logic ALU_ARB_SRC_BR = 1'b1;

    typedef struct packed {
        logic [XLEN-1:0]     a;
        logic [XLEN-1:0]     b;
        logic                is_cond;
        logic [ALU_OP_W-1:0] op;
    } alu_req_t;

    localparam alu_req_t ALU_REQ_IDLE = '{a: '0, b: '0, is_cond: 1'b0, op: ALU_OP_ADD};

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant: the requester that did not win last time wins a conflict.
module alu_arbiter_rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic gnt_valid,
    output logic gnt_idx
);

    always_comb begin
        gnt_valid = req0 | req1;
        gnt_idx   = 1'b0;
        if (req0 && req1) begin
            gnt_idx = ~last_grant;
        end else if (req1) begin
            gnt_idx = 1'b1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between the execute and branch-compare paths and
// captures the result in a single-entry response register.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned TAG_W = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                r0_valid,
    output logic                r0_ready,
    input  logic [XLEN-1:0]     r0_a,
    input  logic [XLEN-1:0]     r0_b,
    input  logic                r0_is_cond,
    input  logic [ALU_OP_W-1:0] r0_op,
    input  logic [TAG_W-1:0]    r0_tag,

    input  logic                r1_valid,
    output logic                r1_ready,
    input  logic [XLEN-1:0]     r1_a,
    input  logic [XLEN-1:0]     r1_b,
    input  logic                r1_is_cond,
    input  logic [ALU_OP_W-1:0] r1_op,
    input  logic [TAG_W-1:0]    r1_tag,

    output logic [XLEN-1:0]     alu_a,
    output logic [XLEN-1:0]     alu_b,
    output logic                alu_is_cond,
    output logic [ALU_OP_W-1:0] alu_op,
    input  logic [XLEN-1:0]     alu_result,

    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [XLEN-1:0]     rsp_result,
    output logic                rsp_src,
    output logic [TAG_W-1:0]    rsp_tag
);

    logic     last_grant;
    logic     gnt_valid;
    logic     gnt_idx;
    logic     can_accept;
    logic     fire;
    alu_req_t req0;
    alu_req_t req1;
    alu_req_t alu_req;

    alu_arbiter_rr_arb2 u_rr_arb2 (
        .req0       (r0_valid),
        .req1       (r1_valid),
        .last_grant (last_grant),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx)
    );

    assign req0 = '{a: r0_a, b: r0_b, is_cond: r0_is_cond, op: r0_op};
    assign req1 = '{a: r1_a, b: r1_b, is_cond: r1_is_cond, op: r1_op};

    // A granted request is accepted whenever the response slot is free or draining.
    assign can_accept = ~rsp_valid | rsp_ready;
    assign fire       = ~rst & can_accept & gnt_valid;
    assign r0_ready   = fire & ~gnt_idx;
    assign r1_ready   = fire &  gnt_idx;

    // The ALU sees the granted operation even under backpressure; idle drives a harmless ADD.
    always_comb begin
        alu_req = ALU_REQ_IDLE;
        if (gnt_valid) begin
            alu_req = gnt_idx ? req1 : req0;
        end
    end

    assign alu_a       = alu_req.a;
    assign alu_b       = alu_req.b;
    assign alu_is_cond = alu_req.is_cond;
    assign alu_op      = alu_req.op;

    // Response register; a fire in the same cycle as a drain refills it back-to-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_src    <= ALU_ARB_SRC_EX;
            rsp_tag    <= '0;
            last_grant <= 1'b1;
        end else if (fire) begin
            rsp_valid  <= 1'b1;
            rsp_result <= alu_result;
            rsp_src    <= gnt_idx ? ALU_ARB_SRC_BR : ALU_ARB_SRC_EX;
            rsp_tag    <= gnt_idx ? r1_tag : r0_tag;
            last_grant <= gnt_idx;
        end else if (rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed, table-driven bench for alu_arbiter with a behavioural ALU model.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int unsigned TAG_W = 4;

    typedef struct packed {
        logic                v;
        logic [XLEN-1:0]     a;
        logic [XLEN-1:0]     b;
        logic                c;
        logic [ALU_OP_W-1:0] op;
        logic [TAG_W-1:0]    tag;
    } rq_t;

    typedef struct packed {
        rq_t             r0;
        rq_t             r1;
        logic            rr;
        logic            e0;
        logic            e1;
        logic            ev;
        logic [XLEN-1:0] eres;
        logic            esrc;
        logic [TAG_W-1:0] etag;
    } vec_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                r0_valid, r0_ready, r0_is_cond;
    logic [XLEN-1:0]     r0_a, r0_b;
    logic [ALU_OP_W-1:0] r0_op;
    logic [TAG_W-1:0]    r0_tag;
    logic                r1_valid, r1_ready, r1_is_cond;
    logic [XLEN-1:0]     r1_a, r1_b;
    logic [ALU_OP_W-1:0] r1_op;
    logic [TAG_W-1:0]    r1_tag;
    logic [XLEN-1:0]     alu_a, alu_b, alu_result;
    logic                alu_is_cond;
    logic [ALU_OP_W-1:0] alu_op;
    logic                rsp_valid, rsp_ready, rsp_src;
    logic [XLEN-1:0]     rsp_result;
    logic [TAG_W-1:0]    rsp_tag;

    int n_cmp = 0;
    int n_err = 0;

    rq_t  prev0, prev1;
    logic prev_rdy0, prev_rdy1;
    logic prev_ok = 1'b0;

    always #5 clk = ~clk;

    alu_arbiter #(.TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .r0_valid    (r0_valid),
        .r0_ready    (r0_ready),
        .r0_a        (r0_a),
        .r0_b        (r0_b),
        .r0_is_cond  (r0_is_cond),
        .r0_op       (r0_op),
        .r0_tag      (r0_tag),
        .r1_valid    (r1_valid),
        .r1_ready    (r1_ready),
        .r1_a        (r1_a),
        .r1_b        (r1_b),
        .r1_is_cond  (r1_is_cond),
        .r1_op       (r1_op),
        .r1_tag      (r1_tag),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_is_cond (alu_is_cond),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_src     (rsp_src),
        .rsp_tag     (rsp_tag)
    );

    // Reference ALU; illegal opcodes yield a sentinel that must pass through untouched.
    always_comb begin
        case (alu_op)
            ALU_OP_ADD: alu_result = alu_a + alu_b;
            ALU_OP_SUB: alu_result = alu_a - alu_b;
            ALU_OP_AND: alu_result = alu_a & alu_b;
            ALU_OP_OR:  alu_result = alu_a | alu_b;
            ALU_OP_XOR: alu_result = alu_a ^ alu_b;
            ALU_OP_LT:  alu_result = {31'b0, alu_is_cond & ($signed(alu_a) < $signed(alu_b))};
            ALU_OP_LTU: alu_result = {31'b0, alu_is_cond & (alu_a < alu_b)};
            default:    alu_result = 32'hDEAD_BEEF;
        endcase
    end

    function automatic rq_t rq(input logic v, input logic [31:0] a, input logic [31:0] b,
                               input logic c, input logic [3:0] op, input logic [3:0] tag);
        rq_t r;
        r = '{v: v, a: a, b: b, c: c, op: op, tag: tag};
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input rq_t q0, input rq_t q1, input logic rr);
        r0_valid = q0.v; r0_a = q0.a; r0_b = q0.b; r0_is_cond = q0.c; r0_op = q0.op; r0_tag = q0.tag;
        r1_valid = q1.v; r1_a = q1.a; r1_b = q1.b; r1_is_cond = q1.c; r1_op = q1.op; r1_tag = q1.tag;
        rsp_ready = rr;
    endtask

    // One cycle: drive at negedge, check readys and the requester hold rule, then the response after the edge.
    task automatic apply(input vec_t v, input string nm);
        @(negedge clk);
        rst = 1'b0;
        drive(v.r0, v.r1, v.rr);
        #1;
        if (prev_ok && prev0.v && !prev_rdy0) chk({nm, " hold_r0"}, 32'(v.r0 == prev0), 32'd1);
        if (prev_ok && prev1.v && !prev_rdy1) chk({nm, " hold_r1"}, 32'(v.r1 == prev1), 32'd1);
        chk({nm, " r0_ready"}, 32'(r0_ready), 32'(v.e0));
        chk({nm, " r1_ready"}, 32'(r1_ready), 32'(v.e1));
        if (!v.r0.v && !v.r1.v) begin
            chk({nm, " idle_alu_a"}, alu_a, 32'd0);
            chk({nm, " idle_alu_op"}, 32'(alu_op), 32'(ALU_OP_ADD));
        end
        prev0 = v.r0; prev1 = v.r1; prev_rdy0 = r0_ready; prev_rdy1 = r1_ready; prev_ok = 1'b1;
        @(posedge clk);
        #1;
        chk({nm, " rsp_valid"}, 32'(rsp_valid), 32'(v.ev));
        if (v.ev) begin
            chk({nm, " rsp_result"}, rsp_result, v.eres);
            chk({nm, " rsp_src"}, 32'(rsp_src), 32'(v.esrc));
            chk({nm, " rsp_tag"}, 32'(rsp_tag), 32'(v.etag));
        end
    endtask

    initial begin
        vec_t vq[$];
        rq_t  nop, s1, l1, ca, cx, cb, cn, cc, cd, ce, q0, q1;

        nop = rq(0, 0, 0, 0, ALU_OP_ADD, 0);
        s1  = rq(1, 10, 3, 0, ALU_OP_SUB, 1);
        l1  = rq(1, 32'hFFFF_FFFF, 1, 1, ALU_OP_LT, 2);
        ca  = rq(1, 5, 7, 0, ALU_OP_ADD, 3);
        cx  = rq(1, 1, 2, 0, 4'hF, 9);
        cb  = rq(1, 1, 1, 0, ALU_OP_ADD, 4);
        cn  = rq(1, 32'hF0, 32'h3C, 0, ALU_OP_AND, 5);
        cc  = rq(1, 2, 3, 0, ALU_OP_ADD, 6);
        cd  = rq(1, 10, 20, 0, ALU_OP_ADD, 7);
        ce  = rq(1, 1, 2, 0, ALU_OP_OR, 8);

        // Conflict after reset: r0 first, then alternate; responses 7/src0 and 1/src1.
        vq.push_back('{s1,  l1,  1'b1, 1'b1, 1'b0, 1'b1, 32'd7, 1'b0, 4'd1});
        vq.push_back('{s1,  l1,  1'b1, 1'b0, 1'b1, 1'b1, 32'd1, 1'b1, 4'd2});
        vq.push_back('{s1,  l1,  1'b1, 1'b1, 1'b0, 1'b1, 32'd7, 1'b0, 4'd1});
        vq.push_back('{s1,  l1,  1'b1, 1'b0, 1'b1, 1'b1, 32'd1, 1'b1, 4'd2});
        vq.push_back('{s1,  nop, 1'b1, 1'b1, 1'b0, 1'b1, 32'd7, 1'b0, 4'd1});
        // Single request, then drain.
        vq.push_back('{ca,  nop, 1'b1, 1'b1, 1'b0, 1'b1, 32'd12, 1'b0, 4'd3});
        vq.push_back('{nop, nop, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 4'd0});
        // Illegal op sentinel passes through.
        vq.push_back('{nop, cx,  1'b1, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 4'd9});
        vq.push_back('{nop, nop, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 4'd0});
        // Backpressure: response held 3 cycles while r1 waits, then r1 fires on release.
        vq.push_back('{cb,  nop, 1'b0, 1'b1, 1'b0, 1'b1, 32'd2, 1'b0, 4'd4});
        vq.push_back('{nop, cn,  1'b0, 1'b0, 1'b0, 1'b1, 32'd2, 1'b0, 4'd4});
        vq.push_back('{nop, cn,  1'b0, 1'b0, 1'b0, 1'b1, 32'd2, 1'b0, 4'd4});
        vq.push_back('{nop, cn,  1'b0, 1'b0, 1'b0, 1'b1, 32'd2, 1'b0, 4'd4});
        vq.push_back('{nop, cn,  1'b1, 1'b0, 1'b1, 1'b1, 32'h30, 1'b1, 4'd5});
        vq.push_back('{nop, nop, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 4'd0});
        // Fairness under stall: last grant was r0, so r1 wins once the stall clears.
        vq.push_back('{cc,  nop, 1'b0, 1'b1, 1'b0, 1'b1, 32'd5, 1'b0, 4'd6});
        vq.push_back('{cd,  ce,  1'b0, 1'b0, 1'b0, 1'b1, 32'd5, 1'b0, 4'd6});
        vq.push_back('{cd,  ce,  1'b0, 1'b0, 1'b0, 1'b1, 32'd5, 1'b0, 4'd6});
        vq.push_back('{cd,  ce,  1'b1, 1'b0, 1'b1, 1'b1, 32'd3, 1'b1, 4'd8});
        vq.push_back('{cd,  nop, 1'b1, 1'b1, 1'b0, 1'b1, 32'd30, 1'b0, 4'd7});
        vq.push_back('{nop, nop, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 4'd0});

        // Reset state, with a request present to show no ready during reset.
        drive(ca, ca, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset r0_ready", 32'(r0_ready), 32'd0);
        chk("reset r1_ready", 32'(r1_ready), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_result", rsp_result, 32'd0);
        chk("reset rsp_src", 32'(rsp_src), 32'd0);
        chk("reset rsp_tag", 32'(rsp_tag), 32'd0);
        drive(nop, nop, 1'b1);

        foreach (vq[i]) apply(vq[i], $sformatf("vec%0d", i));

        // Throughput: eight back-to-back ADDs with no bubbles.
        for (int i = 0; i < 8; i++) begin
            logic [3:0] t;
            t = 4'(i);
            apply('{rq(1, 32'(i), 1, 0, ALU_OP_ADD, t), nop, 1'b1, 1'b1, 1'b0, 1'b1, 32'(i + 1), 1'b0, t},
                  $sformatf("thru%0d", i));
        end
        apply('{nop, nop, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 4'd0}, "thru_drain");

        // Reset mid-flight: pending response discarded, last_grant returns to favour r0.
        apply('{rq(1, 4, 4, 0, ALU_OP_ADD, 1), nop, 1'b0, 1'b1, 1'b0, 1'b1, 32'd8, 1'b0, 4'd1}, "mid_fire");
        q0 = rq(1, 3, 3, 0, ALU_OP_ADD, 3);
        q1 = rq(1, 7, 7, 0, ALU_OP_ADD, 2);
        @(negedge clk);
        rst = 1'b1;
        drive(q0, q1, 1'b1);
        #1;
        chk("mid_rst r0_ready", 32'(r0_ready), 32'd0);
        chk("mid_rst r1_ready", 32'(r1_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("mid_rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst rsp_tag", 32'(rsp_tag), 32'd0);
        prev_ok = 1'b0;
        apply('{q0, q1,  1'b1, 1'b1, 1'b0, 1'b1, 32'd6, 1'b0, 4'd3}, "post_rst0");
        apply('{nop, q1, 1'b1, 1'b0, 1'b1, 1'b1, 32'd14, 1'b1, 4'd2}, "post_rst1");
        apply('{nop, nop, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 4'd0}, "post_rst_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
